ws2812b_rx: RTL
===============

// Module: ws2812b_rx
// PURPOSE
//  Decoder for the WS2812B single-wire LED protocol: receiver counterpart of the ws2812b transmitter.
//  Samples serial_in and classifies each high pulse as bit 0/1 by width, assembling GRB888 pixels.
//  Writes each completed byte into a BGR888 pixel buffer, matching the layout ws2812b reads.
//  Used for TX loopback checking and for emulating an LED chain.
// PARAMETERS
//  CLOCK_HZ        12_000_000  system clock frequency
//  NUMBER_OF_LEDS  16          pixels stored per frame; later pixels are dropped
//  THRESHOLD_NS    400         high width >= threshold -> bit 1, else bit 0
//  MAX_HIGH_NS     850         high width > this is not a data bit (TX idle preamble / stuck line)
//  RESET_NS        50_000      low width >= this ends the frame
//  All are converted to cycles by ceiling: T_CYC = (T_NS*CLOCK_HZ + 1e9-1)/1e9.
// PORTS
//  clock            in   1                    system clock
//  reset            in   1                    synchronous, active-high
//  serial_in        in   1                    async WS2812B data line
//  pixel_address    out  $clog2(NUM_LEDS*3)   byte address; pixel n: B @3n, G @3n+1, R @3n+2
//  pixel_write      out  1                    one-cycle write strobe (no back-pressure)
//  pixel_data       out  8                    byte to write
//  frame_done       out  1                    one-cycle pulse at reset-low detection if >=1 byte written
//  frame_led_count  out  $clog2(NUM_LEDS+1)   complete pixels stored in the last frame; valid with frame_done
//  error            out  1                    one-cycle pulse on a protocol error (causes below)
// BEHAVIOUR
//  Reset: all outputs 0; counters 0; state S_WAIT_RESET. Reset mid-frame discards the frame, no pulses.
//  Input path: 2-flop synchroniser, then a registered edge detector. Widths are counted on the synced signal.
//  Width counters saturate: high at MAX_HIGH_CYC+1, low at RESET_CYC. No wrap-around.
//  States:
//   S_WAIT_RESET: ignore edges until low width reaches RESET_CYC -> S_IDLE (frame_done per rule).
//   S_IDLE: byte/bit/pixel counters 0. Rising edge -> S_HIGH.
//   S_HIGH: count high. On falling edge: bit = (width >= THRESHOLD_CYC); shift into byte MSB-first -> S_LOW.
//           If width exceeds MAX_HIGH_CYC: bit_in_pixel==0 -> S_WAIT_RESET silently; else error -> S_WAIT_RESET.
//   S_LOW: count low. Rising edge -> S_HIGH. Low reaches RESET_CYC -> frame end -> S_IDLE.
//  Byte completion (8th bit): pixel_write=1 on the cycle after the synced falling edge,
//   i.e. 3 clocks after the falling edge on serial_in. Byte order on the wire is G,R,B,
//   written to 3n+1, 3n+2, 3n+0 in that order.
//  pixel_counter increments after the B byte. Once pixel_counter == NUMBER_OF_LEDS, further writes
//   are suppressed. error pulses once per frame, on the first dropped bit.
//  Frame end: a bit_in_pixel!=0 (partial pixel) gives error in the same cycle as frame_done.
//   Bytes already written stay written.
//   frame_led_count = complete pixels (saturated at NUMBER_OF_LEDS), held until the next frame_done.
//  Simultaneous: byte completion never coincides with frame end, because frame end needs a full low period.
//  frame_done is suppressed when no byte was written.
// STRUCTURE
//  ws2812_pkg: pixel_t (GRB packed), ns_to_cycles() ceiling function, BGR byte-offset constants.
//   The transmitter shares this package.
//  Sub-module ws2812b_rx_sync: 2-flop synchroniser + rise/fall strobes (also reusable elsewhere).
//  Top: width counters, state machine, byte shifter, address generator.
// TESTING (CLOCK_HZ=12 MHz: THRESHOLD=5, MAX_HIGH=11, RESET=600 cycles)
//  1. Frame of one pixel GRB 0x123456, then 700-cycle low.
//     -> writes (1,0x12),(2,0x34),(0,0x56), then frame_done, frame_led_count=1, no error.
//  2. High of 4 cycles vs 5 cycles, 8 pulses each.
//     -> bytes 0x00 and 0xFF respectively; 11-cycle high=1, 12-cycle high with bit_in_pixel=0 ignored.
//  3. Loopback from ws2812b (16 LEDs, random RAM) -> RX RAM == TX RAM at frame_done, count=16,
//     TX preamble raises no error.
//  4. 10 bits then reset low -> one write (addr 1), error+frame_done same cycle, count=0.
//  5. 17 pixels -> 48 writes only, single error at bit 385, frame_done with count=16.
//  6. reset asserted mid-byte, then bits without reset low -> no writes until 600-cycle low, then normal decode.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812B definitions: pixel layout, BGR byte offsets and ns-to-cycle conversion.
// Used by both the transmitter and the receiver.
package ws2812_pkg;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    localparam int BYTES_PER_PIXEL = 3;
    localparam int BYTE_OFFSET_B   = 0;
    localparam int BYTE_OFFSET_G   = 1;
    localparam int BYTE_OFFSET_R   = 2;

    typedef enum logic [1:0] {
        S_WAIT_RESET,
        S_IDLE,
        S_HIGH,
        S_LOW
    } rx_state_t;

    // Ceiling conversion so a timing limit is never shortened by rounding.
    function automatic int ns_to_cycles(input longint t_ns, input longint clock_hz);
        return int'((t_ns * clock_hz + 64'sd999_999_999) / 64'sd1_000_000_000);
    endfunction

    // Bytes arrive G, R, B on the wire; map the wire position to the BGR buffer offset.
    function automatic int wire_byte_offset(input int byte_index);
        return (byte_index == 0) ? BYTE_OFFSET_G :
               (byte_index == 1) ? BYTE_OFFSET_R : BYTE_OFFSET_B;
    endfunction

endpackage

// File: rtl/ws2812b_rx_sync.sv
// Two-flop synchroniser for an asynchronous line, with single-cycle rise/fall strobes
// derived from a registered copy of the synchronised level.
module ws2812b_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic serial_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta  <= 1'b0;
            level <= 1'b0;
            prev  <= 1'b0;
        end else begin
            meta  <= serial_in;
            level <= meta;
            prev  <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B receiver: classifies high pulses by width into bits, assembles GRB bytes and
// writes them into a BGR888 pixel buffer; reports frame end and protocol errors.
module ws2812b_rx
    import ws2812_pkg::*;
#(
    parameter int CLOCK_HZ       = 12_000_000,
    parameter int NUMBER_OF_LEDS = 16,
    parameter int THRESHOLD_NS   = 400,
    parameter int MAX_HIGH_NS    = 850,
    parameter int RESET_NS       = 50_000,
    localparam int ADDR_W        = $clog2(NUMBER_OF_LEDS * 3),
    localparam int COUNT_W       = $clog2(NUMBER_OF_LEDS + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               serial_in,
    output logic [ADDR_W-1:0]  pixel_address,
    output logic               pixel_write,
    output logic [7:0]         pixel_data,
    output logic               frame_done,
    output logic [COUNT_W-1:0] frame_led_count,
    output logic               error
);

    localparam int THRESHOLD_CYC = ns_to_cycles(longint'(THRESHOLD_NS), longint'(CLOCK_HZ));
    localparam int MAX_HIGH_CYC  = ns_to_cycles(longint'(MAX_HIGH_NS), longint'(CLOCK_HZ));
    localparam int RESET_CYC     = ns_to_cycles(longint'(RESET_NS), longint'(CLOCK_HZ));
    localparam int HIGH_W        = $clog2(MAX_HIGH_CYC + 2);
    localparam int LOW_W         = $clog2(RESET_CYC + 1);

    logic level;
    logic rise;
    logic fall;

    ws2812b_rx_sync u_sync (
        .clock     (clock),
        .reset     (reset),
        .serial_in (serial_in),
        .level     (level),
        .rise      (rise),
        .fall      (fall)
    );

    logic [HIGH_W-1:0]  high_count;
    logic [LOW_W-1:0]   low_count;
    rx_state_t          state;
    rx_state_t          state_next;
    logic [7:0]         shift_reg;
    logic [2:0]         bit_count;
    logic [1:0]         byte_index;
    logic [COUNT_W-1:0] pixel_counter;
    logic               byte_written;
    logic               drop_reported;

    logic               take_bit;
    logic               abort;
    logic               frame_end;
    logic               bit_value;
    logic               long_high;
    logic               low_at_reset;
    logic               partial;
    logic               storing;
    logic [7:0]         shifted;
    logic [ADDR_W-1:0]  byte_address;

    // Both width counters saturate so long idle or stuck periods never wrap into a valid width.
    always_ff @(posedge clock) begin
        if (reset) begin
            high_count <= '0;
            low_count  <= '0;
        end else begin
            if (!level)
                high_count <= '0;
            else if (high_count <= HIGH_W'(MAX_HIGH_CYC))
                high_count <= high_count + HIGH_W'(1);

            if (level)
                low_count <= '0;
            else if (low_count != LOW_W'(RESET_CYC))
                low_count <= low_count + LOW_W'(1);
        end
    end

    assign bit_value    = (high_count >= HIGH_W'(THRESHOLD_CYC));
    assign long_high    = (high_count > HIGH_W'(MAX_HIGH_CYC));
    assign low_at_reset = (low_count == LOW_W'(RESET_CYC));
    assign partial      = (bit_count != 3'd0) || (byte_index != 2'd0);
    assign storing      = (pixel_counter != COUNT_W'(NUMBER_OF_LEDS));
    assign shifted      = {shift_reg[6:0], bit_value};
    assign byte_address = ADDR_W'(int'(pixel_counter) * BYTES_PER_PIXEL
                                  + wire_byte_offset(int'(byte_index)));

    always_ff @(posedge clock) begin
        if (reset)
            state <= S_WAIT_RESET;
        else
            state <= state_next;
    end

    // An over-long high is checked before the falling edge so a pulse one cycle too wide is rejected.
    always_comb begin
        state_next = state;
        take_bit   = 1'b0;
        abort      = 1'b0;
        frame_end  = 1'b0;
        unique case (state)
            S_WAIT_RESET: begin
                if (low_at_reset) begin
                    state_next = S_IDLE;
                    frame_end  = 1'b1;
                end
            end
            S_IDLE: begin
                if (rise)
                    state_next = S_HIGH;
            end
            S_HIGH: begin
                if (long_high) begin
                    state_next = S_WAIT_RESET;
                    abort      = 1'b1;
                end else if (fall) begin
                    state_next = S_LOW;
                    take_bit   = 1'b1;
                end
            end
            S_LOW: begin
                if (rise) begin
                    state_next = S_HIGH;
                end else if (low_at_reset) begin
                    state_next = S_IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: state_next = S_WAIT_RESET;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_address   <= '0;
            pixel_write     <= 1'b0;
            pixel_data      <= '0;
            frame_done      <= 1'b0;
            frame_led_count <= '0;
            error           <= 1'b0;
            shift_reg       <= '0;
            bit_count       <= '0;
            byte_index      <= '0;
            pixel_counter   <= '0;
            byte_written    <= 1'b0;
            drop_reported   <= 1'b0;
        end else begin
            pixel_write <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;

            if (take_bit) begin
                if (!storing) begin
                    // Buffer full: bits are dropped and not tracked as a partial pixel.
                    if (!drop_reported) begin
                        error         <= 1'b1;
                        drop_reported <= 1'b1;
                    end
                end else begin
                    shift_reg <= shifted;
                    bit_count <= bit_count + 3'd1;
                    if (bit_count == 3'd7) begin
                        pixel_write   <= 1'b1;
                        pixel_data    <= shifted;
                        pixel_address <= byte_address;
                        byte_written  <= 1'b1;
                        if (byte_index == 2'd2) begin
                            byte_index    <= 2'd0;
                            pixel_counter <= pixel_counter + COUNT_W'(1);
                        end else begin
                            byte_index <= byte_index + 2'd1;
                        end
                    end
                end
            end

            // A partial pixel cut short by a long high is reported here, not again at frame end.
            if (abort) begin
                error      <= partial;
                bit_count  <= '0;
                byte_index <= '0;
            end

            if (frame_end) begin
                frame_done <= byte_written;
                if (byte_written)
                    frame_led_count <= pixel_counter;
                error         <= partial;
                bit_count     <= '0;
                byte_index    <= '0;
                pixel_counter <= '0;
                byte_written  <= 1'b0;
                drop_reported <= 1'b0;
            end
        end
    end

endmodule
